// File: rtl/timer_pkg.sv
// Shared definitions for the APB timer count engine.
//   CNT_W      counter / compare width
//   DIV_MAX    largest legal prescaler exponent (ratio 2^div_val)
//   ps_state_t prescaler FSM states
//   ADDR_*     register bank offsets
//   div_limit  terminal prescaler count for a given div_val
package timer_pkg;

  localparam int CNT_W   = 64;
  localparam int DIV_MAX = 8;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_RUN  = 2'd1,
    PS_HOLD = 2'd2
  } ps_state_t;

  localparam logic [7:0] ADDR_TCR   = 8'h00;
  localparam logic [7:0] ADDR_TDR0  = 8'h04;
  localparam logic [7:0] ADDR_TDR1  = 8'h08;
  localparam logic [7:0] ADDR_TCMP0 = 8'h0C;
  localparam logic [7:0] ADDR_TCMP1 = 8'h10;
  localparam logic [7:0] ADDR_TIER  = 8'h14;
  localparam logic [7:0] ADDR_TISR  = 8'h18;
  localparam logic [7:0] ADDR_THCSR = 8'h1C;

  // 2^dv - 1; computed in 9 bits so dv = DIV_MAX yields 8'hFF.
  function automatic logic [7:0] div_limit(input logic [3:0] dv);
    logic [8:0] span;
    span = 9'd1 << dv;
    return 8'(span - 9'd1);
  endfunction

endpackage

// File: rtl/timer_cnt_ctrl_if.sv
// Bundle between the timer register bank (master) and the count engine (slave).
//   master drives: timer_en, div_en, div_val, cnt_wr_lo, cnt_wr_hi, wdata,
//                  cmp_val, int_en, int_clr, dbg_mode, halt_req
//   slave drives:  cnt, cnt_en, halt_ack, int_st, tim_int
interface timer_cnt_ctrl_if;
  import timer_pkg::*;

  logic             timer_en;
  logic             div_en;
  logic [3:0]       div_val;
  logic             cnt_wr_lo;
  logic             cnt_wr_hi;
  logic [31:0]      wdata;
  logic [CNT_W-1:0] cmp_val;
  logic             int_en;
  logic             int_clr;
  logic             dbg_mode;
  logic             halt_req;
  logic [CNT_W-1:0] cnt;
  logic             cnt_en;
  logic             halt_ack;
  logic             int_st;
  logic             tim_int;

  modport master (
    output timer_en, div_en, div_val, cnt_wr_lo, cnt_wr_hi, wdata,
           cmp_val, int_en, int_clr, dbg_mode, halt_req,
    input  cnt, cnt_en, halt_ack, int_st, tim_int
  );

  modport slave (
    input  timer_en, div_en, div_val, cnt_wr_lo, cnt_wr_hi, wdata,
           cmp_val, int_en, int_clr, dbg_mode, halt_req,
    output cnt, cnt_en, halt_ack, int_st, tim_int
  );

endinterface

// File: rtl/timer_prescaler.sv
// Prescaler FSM and count-tick generator.
//   clk, rst_n   clock, asynchronous active-low reset
//   i_timer_en   TCR.timer_en
//   i_div_en     TCR.div_en
//   i_div_val    TCR.div_val (0..DIV_MAX)
//   i_halted     registered debug halt acknowledge
//   o_cnt_en     count tick, high in the cycle the counter advances
module timer_prescaler
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_timer_en,
  input  logic       i_div_en,
  input  logic [3:0] i_div_val,
  input  logic       i_halted,
  output logic       o_cnt_en
);

  ps_state_t  r_state;
  logic [7:0] r_pcnt;
  logic       r_div_en_q;
  logic [3:0] r_div_val_q;

  logic [7:0] w_lim;
  logic       w_div_chg;
  logic       w_run;
  logic       w_at_lim;

  assign w_lim     = div_limit(i_div_val);
  assign w_div_chg = (i_div_en != r_div_en_q) || (i_div_val != r_div_val_q);
  // Halt freezes the prescaler as soon as halt_ack is seen, one cycle before
  // the FSM reaches HOLD; timer_en low kills the tick in the clearing cycle.
  assign w_run     = (r_state == PS_RUN) && !i_halted && i_timer_en;
  assign w_at_lim  = !i_div_en || (r_pcnt == w_lim);
  assign o_cnt_en  = w_run && w_at_lim && !w_div_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= PS_IDLE;
      r_pcnt      <= 8'd0;
      r_div_en_q  <= 1'b0;
      r_div_val_q <= 4'd0;
    end else begin
      r_div_en_q  <= i_div_en;
      r_div_val_q <= i_div_val;

      if (!i_timer_en) begin
        r_state <= PS_IDLE;
      end else begin
        unique case (r_state)
          PS_IDLE: r_state <= PS_RUN;
          PS_RUN:  if (i_halted)  r_state <= PS_HOLD;
          PS_HOLD: if (!i_halted) r_state <= PS_RUN;
          default: r_state <= PS_IDLE;
        endcase
      end

      // A divider reconfiguration restarts the prescale period from zero.
      if (!i_timer_en || w_div_chg || !i_div_en) begin
        r_pcnt <= 8'd0;
      end else if (w_run) begin
        r_pcnt <= (r_pcnt == w_lim) ? 8'd0 : r_pcnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/timer_cnt_ctrl.sv
// Timer count engine: 64-bit counter with word loads, compare-match status,
// interrupt output and debug halt handshake; prescaling in timer_prescaler.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          timer_cnt_ctrl_if.slave (control in, cnt/cnt_en/halt_ack/
//                int_st/tim_int out)
module timer_cnt_ctrl
  import timer_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  timer_cnt_ctrl_if.slave bus
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timer_en_q;
  logic             r_halt_ack;
  logic             r_int_st;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_en;
  logic             w_en_fall;
  logic             w_match_set;

  timer_prescaler u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_timer_en (bus.timer_en),
    .i_div_en   (bus.div_en),
    .i_div_val  (bus.div_val),
    .i_halted   (r_halt_ack),
    .o_cnt_en   (w_cnt_en)
  );

  assign w_en_fall = r_timer_en_q && !bus.timer_en;

  // Software load beats the timer_en clear, which beats the increment.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (bus.cnt_wr_lo || bus.cnt_wr_hi) begin
      if (bus.cnt_wr_lo) w_cnt_nxt[31:0]       = bus.wdata;
      if (bus.cnt_wr_hi) w_cnt_nxt[CNT_W-1:32] = bus.wdata;
    end else if (w_en_fall) begin
      w_cnt_nxt = '0;
    end else if (w_cnt_en) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // The next-value compare raises int_st in the same cycle cnt reaches
  // cmp_val; the current-value compare holds it (over int_clr) while cnt
  // still equals cmp_val.
  assign w_match_set = (r_cnt == bus.cmp_val) || (w_cnt_nxt == bus.cmp_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_timer_en_q <= 1'b0;
      r_halt_ack   <= 1'b0;
      r_int_st     <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_timer_en_q <= bus.timer_en;
      r_halt_ack   <= bus.dbg_mode && bus.halt_req;
      r_int_st     <= w_match_set || (r_int_st && !bus.int_clr);
    end
  end

  assign bus.cnt      = r_cnt;
  assign bus.cnt_en   = w_cnt_en;
  assign bus.halt_ack = r_halt_ack;
  assign bus.int_st   = r_int_st;
  assign bus.tim_int  = r_int_st && bus.int_en;

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
module tb_timer_cnt_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  timer_cnt_ctrl_if bus ();

  timer_cnt_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.timer_en  = 1'b0;
    bus.div_en    = 1'b0;
    bus.div_val   = 4'd0;
    bus.cnt_wr_lo = 1'b0;
    bus.cnt_wr_hi = 1'b0;
    bus.wdata     = 32'd0;
    bus.cmp_val   = 64'hFFFF_0000_FFFF_0000;
    bus.int_en    = 1'b0;
    bus.int_clr   = 1'b0;
    bus.dbg_mode  = 1'b0;
    bus.halt_req  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    step(3);
    n_vec++; if (bus.cnt !== 64'd0) begin n_err++; $display("FAIL reset_cnt: got %0h want 0", bus.cnt); end
    n_vec++; if (bus.cnt_en !== 1'b0) begin n_err++; $display("FAIL reset_cnt_en: got %b want 0", bus.cnt_en); end
    n_vec++; if (bus.halt_ack !== 1'b0) begin n_err++; $display("FAIL reset_halt_ack: got %b want 0", bus.halt_ack); end
    n_vec++; if (bus.int_st !== 1'b0) begin n_err++; $display("FAIL reset_int_st: got %b want 0", bus.int_st); end
    n_vec++; if (bus.tim_int !== 1'b0) begin n_err++; $display("FAIL reset_tim_int: got %b want 0", bus.tim_int); end
  endtask

  task automatic test_free_run();
    do_reset();
    bus.timer_en = 1'b1;
    step(1);
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (bus.cnt_en !== 1'b1) begin n_err++; $display("FAIL free_run_tick[%0d]: got %b want 1", i, bus.cnt_en); end
      n_vec++; if (bus.cnt !== 64'(i)) begin n_err++; $display("FAIL free_run_cnt[%0d]: got %0h want %0h", i, bus.cnt, i); end
      step(1);
    end
    n_vec++; if (bus.cnt !== 64'd10) begin n_err++; $display("FAIL free_run_final: got %0h want a", bus.cnt); end
  endtask

  task automatic test_prescale();
    do_reset();
    bus.div_en   = 1'b1;
    bus.div_val  = 4'd2;
    bus.timer_en = 1'b1;
    step(1);
    for (int c = 1; c <= 12; c++) begin
      n_vec++; if (bus.cnt_en !== ((c % 4) == 0)) begin n_err++; $display("FAIL div4_tick[c%0d]: got %b want %b", c, bus.cnt_en, ((c % 4) == 0)); end
      step(1);
    end
    n_vec++; if (bus.cnt !== 64'd3) begin n_err++; $display("FAIL div4_cnt: got %0h want 3", bus.cnt); end
    step(1);
    // pcnt is 1 here; div_val=1 would hit the limit but the change suppresses the tick
    bus.div_val = 4'd1;
    #1;
    n_vec++; if (bus.cnt_en !== 1'b0) begin n_err++; $display("FAIL div_chg_tick1: got %b want 0", bus.cnt_en); end
    step(1);
    n_vec++; if (bus.cnt_en !== 1'b0) begin n_err++; $display("FAIL div_chg_cleared: got %b want 0", bus.cnt_en); end
    bus.div_val = 4'd0;
    #1;
    n_vec++; if (bus.cnt_en !== 1'b0) begin n_err++; $display("FAIL div_chg_tick0: got %b want 0", bus.cnt_en); end
    step(1);
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (bus.cnt_en !== 1'b1) begin n_err++; $display("FAIL div1_tick[%0d]: got %b want 1", i, bus.cnt_en); end
      n_vec++; if (bus.cnt !== 64'(3 + i)) begin n_err++; $display("FAIL div1_cnt[%0d]: got %0h want %0h", i, bus.cnt, 3 + i); end
      step(1);
    end
    n_vec++; if (bus.cnt !== 64'd6) begin n_err++; $display("FAIL div1_final: got %0h want 6", bus.cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.cmp_val   = 64'd1;
    bus.cnt_wr_lo = 1'b1;
    bus.cnt_wr_hi = 1'b1;
    bus.wdata     = 32'hFFFF_FFFF;
    step(1);
    bus.cnt_wr_lo = 1'b0;
    bus.cnt_wr_hi = 1'b0;
    n_vec++; if (bus.cnt !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL wrap_load: got %0h want ffffffffffffffff", bus.cnt); end
    bus.timer_en = 1'b1;
    step(1);
    n_vec++; if (bus.cnt_en !== 1'b1) begin n_err++; $display("FAIL wrap_tick: got %b want 1", bus.cnt_en); end
    step(1);
    n_vec++; if (bus.cnt !== 64'd0) begin n_err++; $display("FAIL wrap_cnt: got %0h want 0", bus.cnt); end
    n_vec++; if (bus.int_st !== 1'b0) begin n_err++; $display("FAIL wrap_int_st: got %b want 0", bus.int_st); end
    bus.timer_en = 1'b0;
    step(1);
    n_vec++; if (bus.int_st !== 1'b0) begin n_err++; $display("FAIL wrap_int_st2: got %b want 0", bus.int_st); end
  endtask

  task automatic test_compare();
    do_reset();
    bus.cmp_val  = 64'd5;
    bus.int_en   = 1'b1;
    bus.timer_en = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (bus.int_st !== 1'b0) begin n_err++; $display("FAIL cmp_pre[%0d]: got %b want 0", i, bus.int_st); end
      step(1);
    end
    n_vec++; if (bus.cnt !== 64'd5) begin n_err++; $display("FAIL cmp_cnt5: got %0h want 5", bus.cnt); end
    n_vec++; if (bus.int_st !== 1'b1) begin n_err++; $display("FAIL cmp_int_st: got %b want 1", bus.int_st); end
    n_vec++; if (bus.tim_int !== 1'b1) begin n_err++; $display("FAIL cmp_tim_int: got %b want 1", bus.tim_int); end
    bus.int_clr = 1'b1;
    step(1);
    n_vec++; if (bus.int_st !== 1'b1) begin n_err++; $display("FAIL cmp_set_beats_clr: got %b want 1", bus.int_st); end
    bus.int_en = 1'b0;
    #1;
    n_vec++; if (bus.tim_int !== 1'b0) begin n_err++; $display("FAIL cmp_int_en_gate: got %b want 0", bus.tim_int); end
    bus.int_en = 1'b1;
    step(1);
    bus.int_clr = 1'b0;
    n_vec++; if (bus.int_st !== 1'b0) begin n_err++; $display("FAIL cmp_cleared: got %b want 0", bus.int_st); end
    n_vec++; if (bus.tim_int !== 1'b0) begin n_err++; $display("FAIL cmp_tim_int_clr: got %b want 0", bus.tim_int); end
  endtask

  task automatic test_halt();
    do_reset();
    bus.div_en   = 1'b1;
    bus.div_val  = 4'd1;
    bus.timer_en = 1'b1;
    step(3);
    bus.halt_req = 1'b1;
    step(1);
    n_vec++; if (bus.halt_ack !== 1'b0) begin n_err++; $display("FAIL halt_no_dbg: got %b want 0", bus.halt_ack); end
    n_vec++; if (bus.cnt_en !== 1'b1) begin n_err++; $display("FAIL halt_pre_tick: got %b want 1", bus.cnt_en); end
    step(1);
    n_vec++; if (bus.cnt !== 64'd2) begin n_err++; $display("FAIL halt_pre_cnt: got %0h want 2", bus.cnt); end
    bus.dbg_mode = 1'b1;
    step(1);
    n_vec++; if (bus.halt_ack !== 1'b1) begin n_err++; $display("FAIL halt_ack: got %b want 1", bus.halt_ack); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (bus.cnt !== 64'd2) begin n_err++; $display("FAIL halt_frozen_cnt[%0d]: got %0h want 2", i, bus.cnt); end
      n_vec++; if (bus.cnt_en !== 1'b0) begin n_err++; $display("FAIL halt_frozen_tick[%0d]: got %b want 0", i, bus.cnt_en); end
      if (i < 3) step(1);
    end
    bus.halt_req = 1'b0;
    step(1);
    n_vec++; if (bus.halt_ack !== 1'b0) begin n_err++; $display("FAIL halt_release_ack: got %b want 0", bus.halt_ack); end
    n_vec++; if (bus.cnt_en !== 1'b0) begin n_err++; $display("FAIL halt_release_tick: got %b want 0", bus.cnt_en); end
    step(1);
    n_vec++; if (bus.cnt_en !== 1'b1) begin n_err++; $display("FAIL halt_resume_tick: got %b want 1", bus.cnt_en); end
    n_vec++; if (bus.cnt !== 64'd2) begin n_err++; $display("FAIL halt_resume_cnt: got %0h want 2", bus.cnt); end
    step(1);
    n_vec++; if (bus.cnt !== 64'd3) begin n_err++; $display("FAIL halt_resume_inc: got %0h want 3", bus.cnt); end
    n_vec++; if (bus.cnt_en !== 1'b0) begin n_err++; $display("FAIL halt_resume_pcnt: got %b want 0", bus.cnt_en); end
  endtask

  task automatic test_load_clear();
    do_reset();
    bus.timer_en = 1'b1;
    step(3);
    bus.cnt_wr_lo = 1'b1;
    bus.wdata     = 32'h100;
    #1;
    n_vec++; if (bus.cnt_en !== 1'b1) begin n_err++; $display("FAIL load_coincident_tick: got %b want 1", bus.cnt_en); end
    step(1);
    bus.cnt_wr_lo = 1'b0;
    n_vec++; if (bus.cnt !== 64'h100) begin n_err++; $display("FAIL load_lo: got %0h want 100", bus.cnt); end
    step(1);
    bus.cnt_wr_hi = 1'b1;
    bus.wdata     = 32'hA5;
    step(1);
    bus.cnt_wr_hi = 1'b0;
    n_vec++; if (bus.cnt !== 64'h0000_00A5_0000_0101) begin n_err++; $display("FAIL load_hi: got %0h want a500000101", bus.cnt); end
    step(1);
    n_vec++; if (bus.cnt !== 64'h0000_00A5_0000_0102) begin n_err++; $display("FAIL load_then_inc: got %0h want a500000102", bus.cnt); end
    bus.timer_en = 1'b0;
    step(1);
    n_vec++; if (bus.cnt !== 64'd0) begin n_err++; $display("FAIL en_fall_clear: got %0h want 0", bus.cnt); end
    n_vec++; if (bus.cnt_en !== 1'b0) begin n_err++; $display("FAIL en_fall_tick: got %b want 0", bus.cnt_en); end
    bus.cnt_wr_lo = 1'b1;
    bus.wdata     = 32'h55;
    step(1);
    bus.cnt_wr_lo = 1'b0;
    step(1);
    n_vec++; if (bus.cnt !== 64'h55) begin n_err++; $display("FAIL idle_load: got %0h want 55", bus.cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.cmp_val  = 64'd3;
    bus.int_en   = 1'b1;
    bus.timer_en = 1'b1;
    step(6);
    n_vec++; if (bus.int_st !== 1'b1) begin n_err++; $display("FAIL mid_pre_int_st: got %b want 1", bus.int_st); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.cnt !== 64'd0) begin n_err++; $display("FAIL mid_async_cnt: got %0h want 0", bus.cnt); end
    n_vec++; if (bus.int_st !== 1'b0) begin n_err++; $display("FAIL mid_async_int_st: got %b want 0", bus.int_st); end
    n_vec++; if (bus.tim_int !== 1'b0) begin n_err++; $display("FAIL mid_async_tim_int: got %b want 0", bus.tim_int); end
    bus.timer_en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    n_vec++; if (bus.cnt !== 64'd0) begin n_err++; $display("FAIL mid_idle_cnt: got %0h want 0", bus.cnt); end
    bus.timer_en = 1'b1;
    step(1);
    n_vec++; if (bus.cnt_en !== 1'b1) begin n_err++; $display("FAIL mid_restart_tick: got %b want 1", bus.cnt_en); end
    step(3);
    n_vec++; if (bus.cnt !== 64'd3) begin n_err++; $display("FAIL mid_restart_cnt: got %0h want 3", bus.cnt); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_prescale();
    test_wrap();
    test_compare();
    test_halt();
    test_load_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
